// File: rtl/rvc_fetch_align.sv
// Fetch alignment and RVC expansion: buffers fetched words as halfwords and issues 32-bit instructions.
// Define RVC_EXPAND_EN to build the compressed-to-RV32I expander; otherwise 16-bit halfwords issue as illegal.
module rvc_fetch_align #(
    parameter int unsigned BUF_HW   = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] fetch_addr,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_is_c,
    output logic        inst_illegal
);

    localparam int unsigned PTR_W = $clog2(BUF_HW);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [15:0]      hw_buf [BUF_HW];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic [CNT_W-1:0] count;
    logic             drop_lo;

    logic [15:0] head_hw;
    logic [15:0] next_hw;
    logic        is_32;
    logic        push_en;
    logic        pop_en;
    logic [1:0]  push_n;
    logic [1:0]  pop_n;

`ifdef RVC_EXPAND_EN
    // Returns {illegal, expanded}; illegal encodings come back as {16'h0, halfword}.
    function automatic logic [32:0] expand_c(input logic [15:0] h);
        logic [31:0]        x;
        logic               bad;
        logic [4:0]         rd;
        logic [4:0]         rs2;
        logic [4:0]         rdp;
        logic [4:0]         rs2p;
        logic signed [11:0] imm6;
        logic [11:0]        mem_off;
        x       = 32'h0;
        bad     = 1'b0;
        rd      = h[11:7];
        rs2     = h[6:2];
        rdp     = {2'b01, h[9:7]};
        rs2p    = {2'b01, h[4:2]};
        imm6    = {{6{h[12]}}, h[12], h[6:2]};
        mem_off = {5'b0, h[5], h[12:10], h[6], 2'b00};
        case ({h[1:0], h[15:13]})
            5'b00_010: x = {mem_off, rdp, 3'b010, rs2p, 7'b0000011};
            5'b00_110: x = {mem_off[11:5], rs2p, rdp, 3'b010, mem_off[4:0], 7'b0100011};
            5'b01_000: x = {imm6, rd, 3'b000, rd, 7'b0010011};
            5'b01_010: x = {imm6, 5'd0, 3'b000, rd, 7'b0010011};
            5'b01_011: begin
                bad = (imm6 == 12'sd0) || (rd == 5'd2);
                x   = {{14{h[12]}}, h[12], h[6:2], rd, 7'b0110111};
            end
            5'b01_100: begin
                case (h[11:10])
                    2'b00: begin
                        bad = h[12];
                        x   = {7'b0000000, h[6:2], rdp, 3'b101, rdp, 7'b0010011};
                    end
                    2'b01: begin
                        bad = h[12];
                        x   = {7'b0100000, h[6:2], rdp, 3'b101, rdp, 7'b0010011};
                    end
                    2'b10: x = {imm6, rdp, 3'b111, rdp, 7'b0010011};
                    default: begin
                        // h[12]=1 here selects the RV64 word ops
                        bad = h[12];
                        case (h[6:5])
                            2'b00:   x = {7'b0100000, rs2p, rdp, 3'b000, rdp, 7'b0110011};
                            2'b01:   x = {7'b0000000, rs2p, rdp, 3'b100, rdp, 7'b0110011};
                            2'b10:   x = {7'b0000000, rs2p, rdp, 3'b110, rdp, 7'b0110011};
                            default: x = {7'b0000000, rs2p, rdp, 3'b111, rdp, 7'b0110011};
                        endcase
                    end
                endcase
            end
            5'b10_000: begin
                bad = h[12];
                x   = {7'b0000000, h[6:2], rd, 3'b001, rd, 7'b0010011};
            end
            5'b10_100: begin
                bad = (rs2 == 5'd0);
                x   = {7'b0000000, rs2, (h[12] ? rd : 5'd0), 3'b000, rd, 7'b0110011};
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            x = {16'h0, h};
        end
        return {bad, x};
    endfunction
`endif

    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);
    assign head_hw = hw_buf[head];
    assign next_hw = hw_buf[head_p1];
    assign is_32   = (head_hw[1:0] == 2'b11);

    assign fetch_ready = (CNT_W'(BUF_HW) - count) >= CNT_W'(2);
    assign inst_valid  = !redirect && (is_32 ? (count >= CNT_W'(2)) : (count != '0));

    assign push_en = fetch_valid && fetch_ready;
    assign pop_en  = inst_valid && inst_ready;
    assign push_n  = !push_en ? 2'd0 : (drop_lo ? 2'd1 : 2'd2);
    assign pop_n   = !pop_en ? 2'd0 : (is_32 ? 2'd2 : 2'd1);

    always_comb begin
        inst         = 32'h0;
        inst_is_c    = 1'b0;
        inst_illegal = 1'b0;
        if (inst_valid) begin
            if (is_32) begin
                inst = {next_hw, head_hw};
            end else begin
                inst_is_c = 1'b1;
`ifdef RVC_EXPAND_EN
                {inst_illegal, inst} = expand_c(head_hw);
`else
                {inst_illegal, inst} = {1'b1, 16'h0, head_hw};
`endif
            end
        end
    end

    // Halfword storage; slots past count are don't-care so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_en) begin
            if (drop_lo) begin
                hw_buf[tail] <= fetch_data[31:16];
            end else begin
                hw_buf[tail]    <= fetch_data[15:0];
                hw_buf[tail_p1] <= fetch_data[31:16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            drop_lo    <= RESET_PC[1];
            fetch_addr <= {RESET_PC[31:2], 2'b00};
            inst_pc    <= RESET_PC;
        end else if (redirect) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            drop_lo    <= redirect_pc[1];
            fetch_addr <= redirect_pc & ~32'd3;
            inst_pc    <= redirect_pc & ~32'd1;
        end else begin
            if (push_en) begin
                tail       <= tail + PTR_W'(push_n);
                fetch_addr <= fetch_addr + 32'd4;
                drop_lo    <= 1'b0;
            end
            if (pop_en) begin
                head    <= head + PTR_W'(pop_n);
                inst_pc <= inst_pc + (is_32 ? 32'd4 : 32'd2);
            end
            count <= count + CNT_W'(push_n) - CNT_W'(pop_n);
        end
    end

endmodule
